// File: rtl/flag_ctrl.sv
// flag_ctrl: processor status flag register {Z,C,V,N} with ALU update, software
// write, an interrupt-nesting save stack and registered branch-condition evaluation.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   alu_valid         ALU result present this cycle
//   alu_data[15:0]    ALU result
//   alu_carry         ALU carry out
//   upd_mask[3:0]     per-flag ALU update enable {Z,C,V,N}
//   psr_wr            software write of the flag register
//   psr_wdata[3:0]    software write data {Z,C,V,N}
//   cond_req          branch condition evaluation request
//   cond_code[3:0]    condition selector
//   irq_enter         interrupt entry: save flags and clear them
//   irq_exit          interrupt return: restore saved flags
//   err_clr           clear the sticky error bits
//   flags[3:0]        current flag register {Z,C,V,N}
//   cond_valid        evaluation result valid (one cycle after cond_req)
//   cond_true         evaluation result, held while cond_valid is low
//   depth[3:0]        number of occupied save entries
//   stk_ovf           sticky: push attempted while full
//   stk_unf           sticky: pop attempted while empty
//   seq_err           sticky: irq_enter and irq_exit in the same cycle
module flag_ctrl #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [15:0] alu_data,
    input  logic        alu_carry,
    input  logic [3:0]  upd_mask,
    input  logic        psr_wr,
    input  logic [3:0]  psr_wdata,
    input  logic        cond_req,
    input  logic [3:0]  cond_code,
    input  logic        irq_enter,
    input  logic        irq_exit,
    input  logic        err_clr,
    output logic [3:0]  flags,
    output logic        cond_valid,
    output logic        cond_true,
    output logic [3:0]  depth,
    output logic        stk_ovf,
    output logic        stk_unf,
    output logic        seq_err
);

    localparam int unsigned StackW   = STACK_DEPTH * 4;
    localparam logic [3:0]  MaxDepth = 4'(STACK_DEPTH);

    logic [3:0]        flags_q, flags_d;
    logic [3:0]        depth_q, depth_d;
    // Shift-register stack: entry 0 (bits [3:0]) is always the most recent save.
    logic [StackW-1:0] stack_q, stack_d;
    logic [StackW+3:0] stack_push;
    logic              cond_valid_q, cond_true_q, cond_true_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, seq_q, seq_d;

    logic [3:0] alu_flags, alu_next;
    logic       push_req, pop_req, full, empty, do_push, do_pop;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic z, c, v, n;
        z = f[3];
        c = f[2];
        v = f[1];
        n = f[0];
        unique case (code)
            4'd0:  eval_cond = z;
            4'd1:  eval_cond = !z;
            4'd2:  eval_cond = c;
            4'd3:  eval_cond = !c;
            4'd4:  eval_cond = n;
            4'd5:  eval_cond = !n;
            4'd6:  eval_cond = v;
            4'd7:  eval_cond = !v;
            4'd8:  eval_cond = c & !z;
            4'd9:  eval_cond = !c | z;
            4'd10: eval_cond = (n == v);
            4'd11: eval_cond = (n != v);
            4'd12: eval_cond = !z & (n == v);
            4'd13: eval_cond = z | (n != v);
            4'd14: eval_cond = 1'b1;
            4'd15: eval_cond = 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_flags = {(alu_data == 16'h0000), alu_carry, (!alu_carry && alu_data[15]),
                     alu_data[15]};
        alu_next  = (flags_q & ~upd_mask) | (alu_flags & upd_mask);

        // Simultaneous enter/exit cancels both stack operations.
        push_req = irq_enter & ~irq_exit;
        pop_req  = irq_exit & ~irq_enter;
        full     = (depth_q == MaxDepth);
        empty    = (depth_q == 4'd0);
        do_push  = push_req & ~full;
        do_pop   = pop_req & ~empty;

        flags_d = flags_q;
        if (do_pop) begin
            flags_d = stack_q[3:0];
        end else if (push_req) begin
            flags_d = 4'b0000;          // cleared even when the push is refused
        end else if (psr_wr) begin
            flags_d = psr_wdata;
        end else if (alu_valid) begin
            flags_d = alu_next;
        end

        stack_push = {stack_q, flags_q};
        stack_d    = stack_q;
        depth_d    = depth_q;
        if (do_push) begin
            stack_d = stack_push[StackW-1:0];
            depth_d = depth_q + 4'd1;
        end else if (do_pop) begin
            stack_d = stack_q >> 4;
            depth_d = depth_q - 4'd1;
        end

        // Evaluated on forwarded flags so a same-cycle update is visible.
        cond_true_d = cond_req ? eval_cond(cond_code, flags_d) : cond_true_q;

        // A new error event in the same cycle wins over err_clr.
        ovf_d = (push_req & full) | (ovf_q & ~err_clr);
        unf_d = (pop_req & empty) | (unf_q & ~err_clr);
        seq_d = (irq_enter & irq_exit) | (seq_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= 4'b0000;
            depth_q      <= 4'd0;
            cond_valid_q <= 1'b0;
            cond_true_q  <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            seq_q        <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            depth_q      <= depth_d;
            cond_valid_q <= cond_req;
            cond_true_q  <= cond_true_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            seq_q        <= seq_d;
        end
    end

    // Contents beyond depth are never observed, so the stack needs no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign flags      = flags_q;
    assign depth      = depth_q;
    assign cond_valid = cond_valid_q;
    assign cond_true  = cond_true_q;
    assign stk_ovf    = ovf_q;
    assign stk_unf    = unf_q;
    assign seq_err    = seq_q;

endmodule
